// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational RV32 ALU between NUM_REQ requesters, result in a tagged response register.
// Latency: 1 cycle from request fire to rsp_valid; sustains 1 op/cycle while rsp_ready is high.
// Backpressure: while rsp_valid && !rsp_ready every req_ready is low and the response holds steady.
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]    req_funct3,
  input  logic [NUM_REQ*7-1:0]    req_funct7,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_funct3,
  output logic [6:0]              alu_funct7,
  input  logic [31:0]             alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result
);

  logic [ID_W-1:0] rr_ptr;
  logic            slot_free;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand;

  // The response slot can take a new result when empty or draining this cycle.
  // Grants are also held off while reset is asserted so nothing appears accepted.
  assign slot_free = rst_n && (!rsp_valid || rsp_ready);

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    if (slot_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
          cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
        end
        cand = cand_sum[ID_W-1:0];
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!gnt_found && (cand == ID_W'(j)) && req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(j);
          end
        end
      end
    end
  end

  // One-hot accept for the granted requester, zero otherwise.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_found && (gnt_idx == ID_W'(i));
    end
  end

  // Steer the granted operands to the shared ALU; idle inputs are zero.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_funct3 = '0;
    alu_funct7 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_idx == ID_W'(i))) begin
        alu_a      = req_a[32*i +: 32];
        alu_b      = req_b[32*i +: 32];
        alu_funct3 = req_funct3[3*i +: 3];
        alu_funct7 = req_funct7[7*i +: 7];
      end
    end
  end

  // Response register and round-robin pointer; a fire reloads, a bare drain clears valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
      rr_ptr     <= '0;
    end else if (gnt_found) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_id     <= gnt_idx;
      rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule
